snake_row_buffer: RTL and testbench

Consumer of the snake body-position stream. Collects every body segment lying on one requested playfield row during a single full sweep of the stream and publishes the result as a registered occupancy bitmap for the pixel renderer. Sits between the snake core (stream source) and the VGA renderer (row requester). The renderer can fetch a row once per scanline group without walking the shift register itself.

---
 rtl/snake_row_buffer.sv | 109 ++++++++++
 tb/tb_snake_row_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/snake_row_buffer.sv
// snake_row_buffer: captures one playfield row from the snake position stream into a registered bitmap (head tracking under SNAKE_ROW_HEAD_MARK_EN)
module snake_row_buffer #(
  parameter int GAME_WIDTH  = 20,
  parameter int GAME_HEIGHT = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            i_pos_x,
  input  logic [3:0]            i_pos_y,
  input  logic                  i_pos_first,
  input  logic                  i_pos_last,
  input  logic                  i_pos_valid,
  input  logic                  i_row_req,
  input  logic [3:0]            i_row_y,
  output logic                  o_busy,
  output logic                  o_row_ready,
  output logic [GAME_WIDTH-1:0] o_row_bits,
  output logic                  o_row_has_head,
  output logic [4:0]            o_row_head_x
);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] row_y_q, row_y_d;
  logic [GAME_WIDTH-1:0] work_q, work_d, bits_q, bits_d, mark;
  logic busy_q, busy_d, ready_q, ready_d;
  logic accept, beat, restart, publish, hit;
  assign accept  = (state_q == IDLE || state_q == DONE) && i_row_req;
  assign beat    = i_pos_valid && (state_q == CAPTURE || (state_q == WAIT_FIRST && i_pos_first));
  assign restart = beat && i_pos_first;
  assign publish = beat && i_pos_last;
  assign hit     = i_pos_y == row_y_q && row_y_q != 4'd0 && 32'(row_y_q) <= 32'(GAME_HEIGHT) &&
                   i_pos_x != 5'd0 && 32'(i_pos_x) <= 32'(GAME_WIDTH);
  assign mark    = hit ? GAME_WIDTH'(1) << (i_pos_x - 5'd1) : '0;
  // next state, working bitmap accumulation and publish of the finished row
  always_comb begin
    state_d = state_q;
    row_y_d = row_y_q;
    work_d  = work_q;
    bits_d  = bits_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    if (accept) begin
      state_d = WAIT_FIRST;
      row_y_d = i_row_y;
      work_d  = '0;
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else if (beat) begin
      work_d  = (restart ? '0 : work_q) | mark;
      state_d = publish ? DONE : CAPTURE;
      bits_d  = publish ? work_d : bits_q;
      busy_d  = !publish;
      ready_d = publish;
    end
  end
  // state and bitmap registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_y_q <= '0;
      work_q  <= '0;
      bits_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_y_q <= row_y_d;
      work_q  <= work_d;
      bits_q  <= bits_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end
  assign o_busy      = busy_q;
  assign o_row_ready = ready_q;
  assign o_row_bits  = bits_q;
`ifdef SNAKE_ROW_HEAD_MARK_EN
  logic wh_has_q, wh_has_d, oh_has_q, oh_has_d;
  logic [4:0] wh_x_q, wh_x_d, oh_x_q, oh_x_d;
  // the head is the sweep's first beat; it is recorded only when it lands on the requested row
  always_comb begin
    wh_has_d = (accept || restart) ? 1'b0 : wh_has_q;
    wh_x_d   = (accept || restart) ? 5'd0 : wh_x_q;
    wh_has_d = (restart && hit) ? 1'b1 : wh_has_d;
    wh_x_d   = (restart && hit) ? i_pos_x : wh_x_d;
    oh_has_d = publish ? wh_has_d : oh_has_q;
    oh_x_d   = publish ? wh_x_d : oh_x_q;
  end
  // head capture and published head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wh_has_q <= 1'b0;
      wh_x_q   <= '0;
      oh_has_q <= 1'b0;
      oh_x_q   <= '0;
    end else begin
      wh_has_q <= wh_has_d;
      wh_x_q   <= wh_x_d;
      oh_has_q <= oh_has_d;
      oh_x_q   <= oh_x_d;
    end
  end
  assign o_row_has_head = oh_has_q;
  assign o_row_head_x   = oh_x_q;
`else
  assign o_row_has_head = 1'b0;
  assign o_row_head_x   = 5'd0;
`endif
endmodule

// File: tb/tb_snake_row_buffer.sv
// tb_snake_row_buffer: directed self-checking bench for snake_row_buffer
module tb_snake_row_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] pos_x = '0;
  logic [3:0] pos_y = '0, row_y = '0;
  logic pos_first = 1'b0, pos_last = 1'b0, pos_valid = 1'b0, row_req = 1'b0;
  logic busy, ready, has_head;
  logic [19:0] bits;
  logic [4:0] head_x;
  int checks = 0, errors = 0;
`ifdef SNAKE_ROW_HEAD_MARK_EN
  localparam bit HM = 1'b1;
`else
  localparam bit HM = 1'b0;
`endif
  always #5 clk = ~clk;
  snake_row_buffer dut (
    .clk(clk), .rst_n(rst_n), .i_pos_x(pos_x), .i_pos_y(pos_y), .i_pos_first(pos_first),
    .i_pos_last(pos_last), .i_pos_valid(pos_valid), .i_row_req(row_req), .i_row_y(row_y),
    .o_busy(busy), .o_row_ready(ready), .o_row_bits(bits), .o_row_has_head(has_head),
    .o_row_head_x(head_x)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [3:0] y);
    row_req = 1'b1;
    row_y = y;
    tick();
    row_req = 1'b0;
  endtask
  task automatic beat(input logic [4:0] x, input logic [3:0] y, input logic f, input logic l, input logic v);
    pos_x = x;
    pos_y = y;
    pos_first = f;
    pos_last = l;
    pos_valid = v;
    tick();
    pos_first = 1'b0;
    pos_last = 1'b0;
    pos_valid = 1'b0;
  endtask
  task automatic chk_row(input string tag, input logic [19:0] eb, input logic eh, input logic [4:0] ex);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bits"}, 32'(bits), 32'(eb));
    chk({tag, "_has_head"}, 32'(has_head), 32'(eh & HM));
    chk({tag, "_head_x"}, 32'(head_x), HM ? 32'(ex) : 32'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_bits", 32'(bits), 32'd0);
    chk("rst_has_head", 32'(has_head), 32'd0);
    chk("rst_head_x", 32'(head_x), 32'd0);
    rst_n = 1'b1;
    tick();
    req(4'd7);
    chk("basic_acc_busy", 32'(busy), 32'd1);
    chk("basic_acc_ready", 32'(ready), 32'd0);
    beat(5'd10, 4'd7, 1'b1, 1'b0, 1'b1);
    beat(5'd9, 4'd7, 1'b0, 1'b0, 1'b1);
    beat(5'd9, 4'd8, 1'b0, 1'b0, 1'b1);
    chk("basic_mid_busy", 32'(busy), 32'd1);
    chk("basic_mid_ready", 32'(ready), 32'd0);
    beat(5'd9, 4'd9, 1'b0, 1'b1, 1'b1);
    chk_row("basic", 20'h00300, 1'b1, 5'd10);
    req(4'd3);
    chk("wall_acc_ready", 32'(ready), 32'd0);
    beat(5'd5, 4'd3, 1'b1, 1'b0, 1'b1);
    beat(5'd0, 4'd3, 1'b0, 1'b0, 1'b1);
    beat(5'd21, 4'd3, 1'b0, 1'b0, 1'b1);
    beat(5'd5, 4'd3, 1'b0, 1'b0, 1'b1);
    beat(5'd6, 4'd4, 1'b0, 1'b1, 1'b1);
    chk_row("wall", 20'h00010, 1'b1, 5'd5);
    req(4'd2);
    beat(5'd3, 4'd2, 1'b0, 1'b0, 1'b1);
    beat(5'd4, 4'd2, 1'b0, 1'b0, 1'b1);
    beat(5'd5, 4'd2, 1'b0, 1'b1, 1'b1);
    chk("mid_after_tail_busy", 32'(busy), 32'd1);
    chk("mid_after_tail_ready", 32'(ready), 32'd0);
    beat(5'd2, 4'd2, 1'b1, 1'b0, 1'b0);
    chk("mid_invalid_first_busy", 32'(busy), 32'd1);
    beat(5'd7, 4'd2, 1'b1, 1'b0, 1'b1);
    beat(5'd8, 4'd2, 1'b0, 1'b0, 1'b0);
    beat(5'd6, 4'd2, 1'b0, 1'b0, 1'b1);
    beat(5'd6, 4'd3, 1'b0, 1'b0, 1'b1);
    chk("mid_capture_busy", 32'(busy), 32'd1);
    beat(5'd1, 4'd2, 1'b0, 1'b1, 1'b1);
    chk_row("mid", 20'h00061, 1'b1, 5'd7);
    req(4'd1);
    beat(5'd20, 4'd1, 1'b1, 1'b1, 1'b1);
    chk_row("single", 20'h80000, 1'b1, 5'd20);
    req(4'd5);
    beat(5'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    req(4'd9);
    chk("ign_req_busy", 32'(busy), 32'd1);
    chk("ign_req_ready", 32'(ready), 32'd0);
    beat(5'd4, 4'd5, 1'b0, 1'b1, 1'b1);
    chk_row("ign_req", 20'h0000C, 1'b1, 5'd3);
    req(4'd0);
    beat(5'd1, 4'd0, 1'b1, 1'b0, 1'b1);
    beat(5'd2, 4'd0, 1'b0, 1'b1, 1'b1);
    chk_row("row0", 20'h00000, 1'b0, 5'd0);
    req(4'd4);
    beat(5'd2, 4'd4, 1'b1, 1'b0, 1'b1);
    beat(5'd3, 4'd4, 1'b0, 1'b0, 1'b1);
    beat(5'd9, 4'd4, 1'b1, 1'b0, 1'b1);
    beat(5'd10, 4'd4, 1'b0, 1'b1, 1'b1);
    chk_row("restart", 20'h00300, 1'b1, 5'd9);
    req(4'd6);
    beat(5'd4, 4'd6, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_bits", 32'(bits), 32'd0);
    chk("arst_has_head", 32'(has_head), 32'd0);
    chk("arst_head_x", 32'(head_x), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(5'd5, 4'd6, 1'b1, 1'b1, 1'b1);
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(ready), 32'd0);
    chk("post_rst_bits", 32'(bits), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
